// File: rtl/uart_ctrl.sv
// UART controller with a byte-wide register bus, TX/RX FIFOs, programmable baud divider,
// optional parity, one or two stop bits, sticky error flags and a level interrupt.
module uart_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd78
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [2:0] wb_addr,
    input  logic [7:0] wb_data_in,
    output logic [7:0] wb_data_out,
    output logic       wb_ack,
    output logic       tx_bit,
    input  logic       rx_bit,
    output logic       irq
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DepthCnt = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  DataMask = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0]  LastBit  = 3'(DATA_BITS - 1);

    localparam logic [2:0] AddrTx    = 3'd0;
    localparam logic [2:0] AddrRx    = 3'd1;
    localparam logic [2:0] AddrDivLo = 3'd2;
    localparam logic [2:0] AddrDivHi = 3'd3;
    localparam logic [2:0] AddrCtrl  = 3'd4;
    localparam logic [2:0] AddrStat  = 3'd5;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // Bus and configuration state
    logic        ack_q, req_we_q;
    logic [2:0]  req_addr_q;
    logic [7:0]  req_wdata_q, rdata_q, rd_mux;
    logic [15:0] div_q, baud_cnt_q;
    logic [5:0]  ctrl_q;
    logic [2:0]  sticky_q;  // {parity_err, frame_err, overrun}
    logic        req, wr_en, rd_en, div_wr, tick;
    logic [2:0]  sticky_clr, sticky_set;

    // FIFOs
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [AW:0]   tx_cnt_q, rx_cnt_q;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_push_req;
    logic [7:0]    tx_head, rx_head;

    // TX FSM
    tx_state_e  tx_state_q;
    logic [3:0] tx_tcnt_q;
    logic [2:0] tx_idx_q;
    logic [7:0] tx_shift_q;
    logic       tx_par_q, tx_par_en_q, tx_two_q, tx_stop2_q, tx_bit_q;
    logic       tx_start, tx_busy;

    // RX FSM
    rx_state_e            rx_state_q;
    logic [3:0]           rx_tcnt_q;
    logic [2:0]           rx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_sync1_q, rx_sync_q, rx_sample;
    logic                 rx_frame_err_set, rx_par_err_set, rx_ovr_set;

    assign req    = wb_stb & ~ack_q;
    assign wr_en  = ack_q & req_we_q;
    assign rd_en  = ack_q & ~req_we_q;
    assign div_wr = wr_en & ((req_addr_q == AddrDivLo) | (req_addr_q == AddrDivHi));
    assign tick   = (baud_cnt_q == div_q);

    assign tx_full  = (tx_cnt_q == DepthCnt);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DepthCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_head  = tx_mem[tx_rptr_q];
    assign rx_head  = rx_mem[rx_rptr_q];

    assign tx_busy  = (tx_state_q != TxIdle);
    assign tx_start = tick & (tx_state_q == TxIdle) & ctrl_q[3] & ~tx_empty;
    assign tx_pop   = tx_start;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign tx_push  = wr_en & (req_addr_q == AddrTx) & (~tx_full | tx_pop);
    assign rx_pop   = rd_en & (req_addr_q == AddrRx) & ~rx_empty;

    assign rx_sample        = tick & (rx_tcnt_q == 4'd15);
    assign rx_push_req      = (rx_state_q == RxStop) & rx_sample;
    assign rx_push          = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_set       = rx_push_req & rx_full & ~rx_pop;
    assign rx_frame_err_set = rx_push_req & ~rx_sync_q;
    assign rx_par_err_set   = (rx_state_q == RxParity) & rx_sample &
                              (rx_sync_q != (ctrl_q[1] ^ (^rx_shift_q)));

    // Only the bits that were actually reported get cleared; fresh errors survive.
    assign sticky_clr = (rd_en && req_addr_q == AddrStat) ? rdata_q[6:4] : 3'b000;
    assign sticky_set = {rx_par_err_set, rx_frame_err_set, rx_ovr_set};

    always_comb begin
        rd_mux = 8'h00;
        case (wb_addr)
            AddrRx:    rd_mux = rx_empty ? 8'h00 : rx_head;
            AddrDivLo: rd_mux = div_q[7:0];
            AddrDivHi: rd_mux = div_q[15:8];
            AddrCtrl:  rd_mux = {2'b00, ctrl_q};
            AddrStat:  rd_mux = {tx_busy, sticky_q, rx_full, rx_empty, tx_empty, tx_full};
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q       <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 3'd0;
            req_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            ack_q <= req;
            if (req) begin
                req_we_q    <= wb_we;
                req_addr_q  <= wb_addr;
                req_wdata_q <= wb_data_in;
                rdata_q     <= wb_we ? 8'h00 : rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= DIV_RESET;
            ctrl_q     <= 6'h18;
            sticky_q   <= 3'b000;
            baud_cnt_q <= 16'd0;
        end else begin
            if (wr_en) begin
                case (req_addr_q)
                    AddrDivLo: div_q[7:0]  <= req_wdata_q;
                    AddrDivHi: div_q[15:8] <= req_wdata_q;
                    AddrCtrl:  ctrl_q      <= req_wdata_q[5:0];
                    default:   ;
                endcase
            end
            sticky_q   <= (sticky_q & ~sticky_clr) | sticky_set;
            baud_cnt_q <= (div_wr || tick) ? 16'd0 : baud_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= req_wdata_q & DataMask;
        if (rx_push) rx_mem[rx_wptr_q] <= 8'(rx_shift_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    // Framing options are latched at frame start so CTRL writes never corrupt a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q  <= TxIdle;
            tx_tcnt_q   <= 4'd0;
            tx_idx_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            tx_par_q    <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_two_q    <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_bit_q    <= 1'b1;
        end else if (tx_state_q == TxIdle) begin
            if (tx_start) begin
                tx_state_q  <= TxStart;
                tx_bit_q    <= 1'b0;
                tx_tcnt_q   <= 4'd0;
                tx_idx_q    <= 3'd0;
                tx_shift_q  <= tx_head;
                tx_par_q    <= ctrl_q[1] ^ (^tx_head);
                tx_par_en_q <= ctrl_q[0];
                tx_two_q    <= ctrl_q[2];
                tx_stop2_q  <= 1'b0;
            end
        end else if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                case (tx_state_q)
                    TxStart: begin
                        tx_state_q <= TxData;
                        tx_bit_q   <= tx_shift_q[0];
                    end
                    TxData: begin
                        if (tx_idx_q == LastBit) begin
                            tx_state_q <= tx_par_en_q ? TxParity : TxStop;
                            tx_bit_q   <= tx_par_en_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_shift_q[1];
                        end
                    end
                    TxParity: begin
                        tx_state_q <= TxStop;
                        tx_bit_q   <= 1'b1;
                    end
                    default: begin
                        if (tx_two_q && !tx_stop2_q) tx_stop2_q <= 1'b1;
                        else                         tx_state_q <= TxIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx_bit;
            rx_sync_q  <= rx_sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_tcnt_q  <= 4'd0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= '0;
        end else if (rx_state_q == RxIdle) begin
            if (tick && !rx_sync_q && ctrl_q[4]) begin
                rx_state_q <= RxStart;
                rx_tcnt_q  <= 4'd0;
            end
        end else if (rx_state_q == RxStart) begin
            if (tick) begin
                if (rx_tcnt_q == 4'd7) begin
                    // Mid-start sample: a high line here was only a glitch.
                    rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    rx_tcnt_q  <= 4'd0;
                    rx_idx_q   <= 3'd0;
                end else begin
                    rx_tcnt_q <= rx_tcnt_q + 4'd1;
                end
            end
        end else if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
                case (rx_state_q)
                    RxData: begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_idx_q == LastBit) rx_state_q <= ctrl_q[0] ? RxParity : RxStop;
                        else                     rx_idx_q   <= rx_idx_q + 3'd1;
                    end
                    RxParity: rx_state_q <= RxStop;
                    default:  rx_state_q <= RxIdle;
                endcase
            end
        end
    end

    assign wb_ack      = ack_q;
    assign wb_data_out = rdata_q;
    assign tx_bit      = tx_bit_q;
    assign irq         = ctrl_q[5] & (~rx_empty | (|sticky_q));

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: register vector table, TX/RX scoreboards and framing corner cases.
module tb_uart_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wb_stb = 1'b0;
    logic       wb_we = 1'b0;
    logic [2:0] wb_addr = 3'd0;
    logic [7:0] wb_data_in = 8'h00;
    logic [7:0] wb_data_out;
    logic       wb_ack, tx_bit, rx_bit, irq;
    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    assign rx_bit = loop_en ? tx_bit : rx_drv;

    uart_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data_in  (wb_data_in),
        .wb_data_out (wb_data_out),
        .wb_ack      (wb_ack),
        .tx_bit      (tx_bit),
        .rx_bit      (rx_bit),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                       output logic [7:0] rd);
        int n;
        wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data_in = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wb_ack !== 1'b1 && n < 4);
        check("bus_ack_latency", 16'(n), 16'd1);
        rd = wb_data_out;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;
        check("bus_ack_drop", {15'd0, wb_ack}, 16'd0);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] wd);
        logic [7:0] dummy;
        bus(1'b1, addr, wd, dummy);
    endtask

    task automatic rd_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        bus(1'b0, addr, 8'h00, d);
        check(name, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic line(input logic v, input int n);
        rx_drv = v;
        clks(n);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par_bit,
                           input logic stop_bit);
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) line(d[i], 16);
        if (par_en) line(par_bit, 16);
        line(stop_bit, 16);
        line(1'b1, 32);
    endtask

    // Decode one frame from tx_bit (DIV=0, 16 clk per bit) and score it.
    task automatic tx_expect(input logic par_en, input logic par_odd);
        int n;
        logic [7:0] d;
        n = 0;
        while (tx_bit === 1'b1 && n < 400) begin
            clks(1);
            n++;
        end
        check("tx_frame_start", {15'd0, tx_bit}, 16'd0);
        if (tx_bit !== 1'b0) return;
        clks(8);
        check("tx_start_bit", {15'd0, tx_bit}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            clks(16);
            d[i] = tx_bit;
        end
        if (par_en) begin
            clks(16);
            check("tx_parity", {15'd0, tx_bit}, {15'd0, par_odd ^ (^d)});
        end
        clks(16);
        check("tx_stop_bit", {15'd0, tx_bit}, 16'd1);
        if (tx_sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected_frame: got 0x%02h, expected no frame", d);
        end else begin
            check("tx_byte", {8'h00, d}, {8'h00, tx_sb.pop_front()});
        end
    endtask

    task automatic rx_expect(input string name);
        logic [7:0] exp;
        exp = (rx_sb.size() > 0) ? rx_sb.pop_front() : 8'h00;
        rd_check(name, 3'd1, exp);
    endtask

    initial begin
        logic samp[160];
        int   cnt;
        logic [7:0] b;

        // Register table: {we, addr, wdata, expected read data}
        vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h18});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'h4E});
        vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h06});
        vecs.push_back('{1'b0, 3'd6, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd3, 8'h12, 8'h00});
        vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h12});
        vecs.push_back('{1'b1, 3'd2, 8'h34, 8'h00});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'h34});
        vecs.push_back('{1'b1, 3'd4, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h3F});
        vecs.push_back('{1'b1, 3'd7, 8'hAA, 8'h00});
        vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd3, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd2, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 3'd4, 8'h18, 8'h00});
        vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h18});

        clks(3);
        check("reset_tx_bit", {15'd0, tx_bit}, 16'd1);
        check("reset_ack", {15'd0, wb_ack}, 16'd0);
        check("reset_rdata", {8'h00, wb_data_out}, 16'h0000);
        check("reset_irq", {15'd0, irq}, 16'd0);
        reset = 1'b0;
        clks(2);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wd);
            else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // 0xA5 waveform with DIV=0, CTRL=0x18
        wr(3'd0, 8'hA5);
        cnt = 0;
        while (tx_bit === 1'b1 && cnt < 50) begin
            clks(1);
            cnt++;
        end
        check("tx_start_latency", 16'(cnt), 16'd1);
        for (int i = 0; i < 160; i++) begin
            samp[i] = tx_bit;
            clks(1);
        end
        b = 8'hA5;
        for (int w = 0; w < 10; w++) begin
            logic lvl;
            int   same;
            lvl  = (w == 0) ? 1'b0 : (w == 9) ? 1'b1 : b[w-1];
            same = 0;
            for (int k = 0; k < 16; k++) if (samp[w*16+k] === lvl) same++;
            check($sformatf("a5_bit%0d_width", w), 16'(same), 16'd16);
        end
        rd_check("a5_status_after", 3'd5, 8'h06);

        // Loopback with odd parity
        wr(3'd4, 8'h1B);
        loop_en = 1'b1;
        foreach (vecs[i]) ;
        b = 8'h00; rx_sb.push_back(b); wr(3'd0, b);
        b = 8'hFF; rx_sb.push_back(b); wr(3'd0, b);
        b = 8'h3C; rx_sb.push_back(b); wr(3'd0, b);
        clks(700);
        rd_check("loop_status", 3'd5, 8'h02);
        for (int i = 0; i < 3; i++) rx_expect($sformatf("loop_rx%0d", i));
        rd_check("loop_status_drained", 3'd5, 8'h06);
        loop_en = 1'b0;

        // Bad parity and bad stop bit
        wr(3'd4, 8'h19);
        rx_sb.push_back(8'h5A);
        send_rx(8'h5A, 1'b1, 1'b1, 1'b0);
        rd_check("err_status", 3'd5, 8'h62);
        rd_check("err_status_cleared", 3'd5, 8'h02);
        wr(3'd4, 8'h39);
        check("irq_rx_pending", {15'd0, irq}, 16'd1);
        rx_expect("err_rx_byte");
        check("irq_rx_drained", {15'd0, irq}, 16'd0);

        // RX overrun
        wr(3'd4, 8'h18);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 29 + 1);
            if (i < 16) rx_sb.push_back(b);
            send_rx(b, 1'b0, 1'b0, 1'b1);
        end
        rd_check("ovr_status", 3'd5, 8'h1A);
        for (int i = 0; i < 16; i++) rx_expect($sformatf("ovr_rx%0d", i));
        rx_expect("ovr_rx_empty_read");
        rd_check("ovr_status_after", 3'd5, 8'h06);

        // TX FIFO full with tx_en=0, then release
        wr(3'd4, 8'h10);
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 7);
            if (i < 16) tx_sb.push_back(b);
            wr(3'd0, b);
        end
        rd_check("txfull_status", 3'd5, 8'h05);
        wr(3'd4, 8'h18);
        for (int i = 0; i < 16; i++) tx_expect(1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx_bit !== 1'b1) cnt++;
            clks(1);
        end
        check("tx_no_extra_frame", 16'(cnt), 16'd0);
        rd_check("txfull_status_after", 3'd5, 8'h06);

        // Short low pulse on rx_bit
        line(1'b0, 4);
        line(1'b1, 40);
        rd_check("glitch_status", 3'd5, 8'h06);

        // Reset during a TX frame
        wr(3'd0, 8'h00);
        clks(50);
        rd_check("midframe_status", 3'd5, 8'h86);
        check("midframe_tx_low", {15'd0, tx_bit}, 16'd0);
        reset = 1'b1;
        clks(1);
        check("abort_tx_bit", {15'd0, tx_bit}, 16'd1);
        check("abort_ack", {15'd0, wb_ack}, 16'd0);
        check("abort_rdata", {8'h00, wb_data_out}, 16'h0000);
        check("abort_irq", {15'd0, irq}, 16'd0);
        reset = 1'b0;
        clks(2);
        rd_check("abort_status", 3'd5, 8'h06);
        rd_check("abort_ctrl", 3'd4, 8'h18);
        rd_check("abort_div_lo", 3'd2, 8'h4E);
        rd_check("abort_div_hi", 3'd3, 8'h00);
        check("abort_tx_idle", {15'd0, tx_bit}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
